// File: rtl/irq_controller_if.sv
// irq_controller_if: interrupt request/acknowledge signals between the pipeline and irq_controller
interface irq_controller_if;
    logic [2:0]  irq_sign;
    logic [2:0]  irq_mask;
    logic        irq_disable;
    logic        irq_ack;
    logic        eret;
    logic        irq_req;
    logic [1:0]  irq_id;
    logic [31:0] irq_vector;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    modport master (
        output irq_sign, irq_mask, irq_disable, irq_ack, eret,
        input  irq_req, irq_id, irq_vector, pending, in_service
    );

    modport slave (
        input  irq_sign, irq_mask, irq_disable, irq_ack, eret,
        output irq_req, irq_id, irq_vector, pending, in_service
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, fixed-priority, nesting interrupt source for the CP0 path
module irq_controller #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_2       = 32'h0000_0000,
    parameter logic [31:0] VEC_1       = 32'h0000_0600,
    parameter logic [31:0] VEC_0       = 32'h0000_0800
) (
    input logic             clk,
    input logic             rst_n,
    irq_controller_if.slave bus
);
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0] hist_q, pend_q, pend_d, insv_q, insv_d;
    logic [2:0] rise, elig, sel, ret_sel, ack_oh, ret_oh;

    // A line may only preempt when it sits above every line already in service
    always_comb begin
        rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
        elig    = pend_q & bus.irq_mask & {3{~bus.irq_disable}}
                & {~insv_q[2], ~|insv_q[2:1], ~|insv_q};
        sel     = elig[2] ? 3'b100 : elig[1] ? 3'b010 : elig[0] ? 3'b001 : 3'b000;
        ret_sel = insv_q[2] ? 3'b100 : insv_q[1] ? 3'b010 : insv_q[0] ? 3'b001 : 3'b000;
        ack_oh  = {3{bus.irq_ack}} & sel;
        ret_oh  = {3{bus.eret}} & ret_sel;
        pend_d  = (pend_q & ~ack_oh) | rise;
        insv_d  = (insv_q & ~ret_oh) | ack_oh;
    end

    assign bus.irq_req    = |elig;
    assign bus.irq_id     = sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
    assign bus.irq_vector = sel[2] ? VEC_2 : sel[1] ? VEC_1 : sel[0] ? VEC_0 : 32'h0;
    assign bus.pending    = pend_q;
    assign bus.in_service = insv_q;

    // Synchronise raw lines, track history for edge detection, update pending and nesting state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
            pend_q <= '0;
            insv_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_sign};
            hist_q <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
            insv_q <= insv_d;
        end
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt source side of the CPU's CP0 interrupt path. It synchronises the raw IO interrupt lines and turns each rising edge into a latched pending request. It arbitrates by fixed priority against the mask, the global disable and the lines already in service, and presents one request with its entrance vector to the pipeline. The pipeline answers with `irq_ack` when it takes the request, saving EPC and redirecting the PC, and with `eret` when the handler returns. Nested interrupts are allowed only for strictly higher priority.

## Interface
- `SYNC_STAGES`, 2, flip-flop depth of each input synchroniser (≥2)
- `VEC_2`, 32'h0000_0000, entrance address for line 2 (highest priority)
- `VEC_1`, 32'h0000_0600, entrance address for line 1
- `VEC_0`, 32'h0000_0800, entrance address for line 0 (lowest priority)

- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `irq_sign`  in  3  raw interrupt lines from IO, asynchronous; an event is a 0→1 transition
- `irq_mask`  in  3  CP0 mask register; bit i = 1 enables line i
- `irq_disable`  in  1  CP0 global disable; 1 blocks all new requests
- `irq_ack`  in  1  one-cycle pulse: CPU accepts the request currently presented
- `eret`  in  1  one-cycle pulse: CPU returns from the current handler
- `irq_req`  out  1  a request is presented
- `irq_id`  out  2  index of the presented line; 0 when `irq_req`=0
- `irq_vector`  out  32  entrance address of `irq_id`; 0 when `irq_req`=0
- `pending`  out  3  latched, unserviced events per line
- `in_service`  out  3  lines whose handler is active (nesting stack)

## Operation
- Each `irq_sign[i]` passes through a `SYNC_STAGES`-deep flip-flop chain. A history flop holds the previous chain output. A detected edge is chain output = 1 and history = 0.
- A detected edge sets `pending[i]`. Repeated edges while pending collapse into one event.
- A line i is eligible when all of these hold:
  - `pending[i]`=1
  - `irq_mask[i]`=1
  - `irq_disable`=0
  - i is greater than the index of the highest set bit of `in_service`, or `in_service`=0
- `irq_req` = any line eligible. `irq_id` = the highest eligible index. `irq_vector` = `VEC_<irq_id>`.
  - These three outputs are combinational from registered state and the mask/disable inputs only. They never depend on `irq_ack` or `eret` in the same cycle.
- `irq_ack` with `irq_req`=1: clear `pending[irq_id]` and set `in_service[irq_id]`.
- `irq_ack` with `irq_req`=0 is ignored.
- `eret`: clear the highest set bit of `in_service` as it stood before this edge. With `in_service`=0 it is ignored.
- Masked or disabled lines keep their pending bit. They request as soon as they become eligible.

Simultaneous events:
- Edge detected on line i and `irq_ack` for line i in the same cycle: `pending[i]` ends at 1, because the new event is kept. `in_service[i]` is still set.
- `irq_ack` and `eret` in the same cycle: eret clears its bit, chosen from the old `in_service`, and ack sets its bit. Both apply.
- `irq_ack` for line i cannot collide with an eret clearing bit i, because the nesting rule requires i to be above every in-service bit.

Reset:
- All flops are cleared: synchronisers, history, `pending`, `in_service`.
- Outputs after reset: `irq_req`=0, `irq_id`=0, `irq_vector`=0, `pending`=0, `in_service`=0.
- A line already high when `rst_n` rises produces one event, because history resets to 0.
- Reset asserted mid-handler drops all pending and in-service state immediately, without waiting for a clock edge.

## Timing
- Input latency: take a raw 0→1 first sampled at edge E0. `pending[i]` and `irq_req` become visible after edge E0+`SYNC_STAGES`. With default 2, that is 2 edges.
- Minimum detectable pulse is one full clock high then one full clock low. Shorter pulses are not guaranteed to be detected.
- `irq_ack` sampled at edge A takes effect after A:
  - `irq_req` falls in the cycle after A, or re-presents if another eligible line exists.
  - The new `in_service` may block lower lines from that cycle on.
- `eret` sampled at edge R takes effect after R. A blocked lower pending line requests in the cycle after R.
- Mask, disable and `in_service` changes affect `irq_req` combinationally. No extra cycles.
- No internal FSM beyond `in_service`. Nesting depth is at most 3, one level per line.

## Test plan
- Reset release with `irq_sign`=000, then raise line 1 → after 2 edges `pending`=010, `irq_req`=1, `irq_id`=1, `irq_vector`=0x600. Ack → `pending`=000, `in_service`=010, `irq_req`=0.
- Lines 0 and 2 rise in the same cycle → `irq_id`=2, `irq_vector`=0x0. Ack → `in_service`=100 and line 0 stays blocked. `eret` → `in_service`=000, `irq_id`=0, `irq_vector`=0x800.
- Nesting:
  - In service on line 0, raise line 2 → `irq_req`=1, `irq_id`=2. Ack → `in_service`=101.
  - Raise line 1 → `irq_req` stays 0.
  - `eret` → `in_service`=001 and line 1 presents.
- `irq_mask`=011 and line 2 rises → `pending`=100, `irq_req`=0. Set mask to 111 → `irq_req`=1 in the same cycle. Drive `irq_disable`=1 → `irq_req`=0 with `pending` unchanged.
- Line 1 edge detected in the same cycle as the ack of line 1 → after the edge, `pending`=010 and `in_service`=010.
  - A 1-cycle 0→1→0 glitch shorter than one clock must not be required to register.
- Assert `rst_n`=0 asynchronously with `in_service`=011 and `pending`=100 → all outputs 0 before the next clock edge.
  - If line 2 is still high at release, `pending`=100 2 edges later.
